// File: rtl/fir_sequencer.sv
// fir_sequencer: control FSM for the FIR datapath.
// Accepts one sample per in_valid/in_ready handshake, strobes the delay-line
// load and accumulator clear, walks tap_sel across every coefficient, delays
// the issue strobe by the multiplier latency to form acc_load, and holds the
// finished result behind an out_valid/out_ready handshake.
module fir_sequencer #(
  parameter int TAPS         = 8,
  parameter int MULT_LATENCY = 3,
  parameter int CNT_W        = $clog2(TAPS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sample_load,
  output logic             acc_clear,
  output logic [CNT_W-1:0] tap_sel,
  output logic             issue_valid,
  output logic             acc_load,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             flush,
  output logic             busy
);

  // The drain counter must hold MULT_LATENCY-1; keep at least one bit.
  localparam int DRAIN_W = (MULT_LATENCY > 1) ? $clog2(MULT_LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [CNT_W-1:0]        tap_cnt;
  logic [DRAIN_W-1:0]      drain_cnt;
  logic [MULT_LATENCY-1:0] lat_pipe;
  logic                    last_tap;
  logic                    drain_done;
  logic                    handshake;

  assign last_tap   = (tap_cnt == CNT_W'(TAPS - 1));
  assign drain_done = (drain_cnt == '0);

  // State register; an abort or reset always lands in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; flush overrides every other transition.
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid)   state_next = ISSUE;
        ISSUE:   if (last_tap)   state_next = DRAIN;
        DRAIN:   if (drain_done) state_next = DONE;
        DONE:    if (out_ready)  state_next = IDLE;
        default:                 state_next = IDLE;
      endcase
    end
  end

  // Output decode; in_valid is masked while reset is held so no stray load escapes.
  always_comb begin
    in_ready    = (state == IDLE);
    busy        = (state != IDLE);
    out_valid   = (state == DONE);
    issue_valid = (state == ISSUE);
    handshake   = (state == IDLE) & in_valid & ~flush & ~reset;
    sample_load = handshake;
    acc_clear   = handshake | (flush & ~reset);
    acc_load    = lat_pipe[MULT_LATENCY-1];
    tap_sel     = tap_cnt;
  end

  // Tap index: counts 0..TAPS-1 while issuing and sits at 0 everywhere else.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tap_cnt <= '0;
    end else if (flush) begin
      tap_cnt <= '0;
    end else if ((state == ISSUE) && !last_tap) begin
      tap_cnt <= tap_cnt + CNT_W'(1);
    end else begin
      tap_cnt <= '0;
    end
  end

  // Drain counter: loaded on the last issue so DRAIN lasts MULT_LATENCY cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drain_cnt <= '0;
    end else if (flush) begin
      drain_cnt <= '0;
    end else if ((state == ISSUE) && last_tap) begin
      drain_cnt <= DRAIN_W'(MULT_LATENCY - 1);
    end else if ((state == DRAIN) && !drain_done) begin
      drain_cnt <= drain_cnt - DRAIN_W'(1);
    end
  end

  // Latency pipe mirrors the multiplier depth; flushing it kills in-flight products.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_pipe <= '0;
    end else if (flush) begin
      lat_pipe <= '0;
    end else begin
      lat_pipe <= (lat_pipe << 1) | MULT_LATENCY'(issue_valid);
    end
  end

endmodule

// File: tb/tb_fir_sequencer.sv
// tb_fir_sequencer: directed, table-driven bench for fir_sequencer.
// One instance uses TAPS=8/MULT_LATENCY=3, a second uses TAPS=2/MULT_LATENCY=1.
module tb_fir_sequencer;

  logic       clk = 1'b0;
  logic       reset;

  logic       in_valid, out_ready, flush;
  logic       in_ready, sample_load, acc_clear;
  logic [2:0] tap_sel;
  logic       issue_valid, acc_load, out_valid, busy;

  logic       s_in_valid, s_out_ready, s_flush;
  logic       s_in_ready, s_sample_load, s_acc_clear;
  logic [0:0] s_tap_sel;
  logic       s_issue_valid, s_acc_load, s_out_valid, s_busy;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    string      name;
    logic       in_valid;
    logic       out_ready;
    logic       flush;
    logic       ir;
    logic       sl;
    logic       ac;
    logic [2:0] tap;
    logic       is;
    logic       al;
    logic       ov;
    logic       bz;
  } vec_t;

  vec_t vecs[$];

  fir_sequencer #(.TAPS(8), .MULT_LATENCY(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .sample_load(sample_load), .acc_clear(acc_clear), .tap_sel(tap_sel),
    .issue_valid(issue_valid), .acc_load(acc_load), .out_valid(out_valid),
    .out_ready(out_ready), .flush(flush), .busy(busy)
  );

  fir_sequencer #(.TAPS(2), .MULT_LATENCY(1)) dut_small (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .sample_load(s_sample_load), .acc_clear(s_acc_clear), .tap_sel(s_tap_sel),
    .issue_valid(s_issue_valid), .acc_load(s_acc_load), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .flush(s_flush), .busy(s_busy)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  function automatic void addVec(string nm, logic iv, logic ordy, logic fl,
                                 logic ir, logic sl, logic ac, int tap,
                                 logic is, logic al, logic ov, logic bz);
    vec_t v;
    v.name = nm; v.in_valid = iv; v.out_ready = ordy; v.flush = fl;
    v.ir = ir; v.sl = sl; v.ac = ac; v.tap = 3'(tap);
    v.is = is; v.al = al; v.ov = ov; v.bz = bz;
    vecs.push_back(v);
  endfunction

  task automatic applyStimulus(input vec_t v);
    in_valid  = v.in_valid;
    out_ready = v.out_ready;
    flush     = v.flush;
  endtask

  task automatic checkOutput(input vec_t v);
    logic [9:0] got, req;
    got = {in_ready, sample_load, acc_clear, tap_sel, issue_valid, acc_load, out_valid, busy};
    req = {v.ir, v.sl, v.ac, v.tap, v.is, v.al, v.ov, v.bz};
    n_vec++;
    if (got !== req) begin
      n_miss++;
      $display("[TB] FAIL %s: ir/sl/ac/tap/iv/al/ov/bz got %b required %b", v.name, got, req);
    end
  endtask

  task automatic checkBit(input string nm, input logic got, input logic req);
    n_vec++;
    if (got !== req) begin
      n_miss++;
      $display("[TB] FAIL %s: got %b required %b", nm, got, req);
    end
  endtask

  // Watchdog so the run always ends even if sequencing goes wrong.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t rv;
    vec_t v;

    reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    s_in_valid = 1'b0; s_out_ready = 1'b0; s_flush = 1'b0;

    rv.name = "reset_values"; rv.in_valid = 1'b0; rv.out_ready = 1'b0; rv.flush = 1'b0;
    rv.ir = 1'b1; rv.sl = 1'b0; rv.ac = 1'b0; rv.tap = 3'd0;
    rv.is = 1'b0; rv.al = 1'b0; rv.ov = 1'b0; rv.bz = 1'b0;

    // Single sample, out_ready high: rows 0..13 are reused after the async reset.
    addVec("single_c0", 1, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++)
      addVec($sformatf("single_c%0d", k), 0, 1, 0, 0, 0, 0, k - 1, 1, (k >= 4), 0, 1);
    for (int k = 9; k <= 11; k++)
      addVec($sformatf("single_c%0d", k), 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    addVec("single_c12", 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    addVec("single_c13", 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);

    // Output backpressure: out_ready low for 5 DONE cycles, in_valid pushing.
    addVec("bp_c0", 1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++)
      addVec($sformatf("bp_c%0d", k), 0, 0, 0, 0, 0, 0, k - 1, 1, (k >= 4), 0, 1);
    for (int k = 9; k <= 11; k++)
      addVec($sformatf("bp_c%0d", k), 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    for (int k = 12; k <= 16; k++)
      addVec($sformatf("bp_c%0d", k), 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    addVec("bp_c17", 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    addVec("bp_c18", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

    // Flush mid-ISSUE at cycle 5: no acc_load may follow.
    addVec("flush_c0", 1, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++)
      addVec($sformatf("flush_c%0d", k), 0, 1, 0, 0, 0, 0, k - 1, 1, (k >= 4), 0, 1);
    addVec("flush_c5", 0, 1, 1, 0, 0, 1, 4, 1, 1, 0, 1);
    for (int k = 6; k <= 9; k++)
      addVec($sformatf("flush_c%0d", k), 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);

    // Flush coincident with in_valid in IDLE.
    addVec("flush_idle_c0", 1, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0);
    addVec("flush_idle_c1", 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);

    #1;
    rv.name = "reset_held";
    checkOutput(rv);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    // Reset then idle for 20 cycles.
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #4;
      rv.name = $sformatf("idle_%0d", k);
      checkOutput(rv);
    end

    // Table-driven vectors.
    foreach (vecs[i]) begin
      @(posedge clk);
      #1 applyStimulus(vecs[i]);
      #3 checkOutput(vecs[i]);
    end

    // Asynchronous reset during DRAIN (cycle 10 of a sample).
    for (int k = 0; k <= 10; k++) begin
      @(posedge clk);
      #1 applyStimulus(vecs[k]);
      if (k == 10) begin
        checkBit("pre_reset_acc_load", acc_load, 1'b1);
        checkBit("pre_reset_busy", busy, 1'b1);
      end
    end
    #1 reset = 1'b1;
    #1;
    rv.name = "async_reset";
    checkOutput(rv);
    in_valid = 1'b1;
    #1;
    checkBit("reset_masks_sample_load", sample_load, 1'b0);
    checkBit("reset_masks_acc_clear", acc_clear, 1'b0);
    #2;
    reset = 1'b0;
    in_valid = 1'b0;

    // Full sequence again after the reset.
    for (int k = 0; k <= 13; k++) begin
      v = vecs[k];
      v.name = {"rerun_", v.name};
      @(posedge clk);
      #1 applyStimulus(v);
      #3 checkOutput(v);
    end

    // Small instance: single sample.
    for (int k = 0; k <= 5; k++) begin
      @(posedge clk);
      #1;
      s_in_valid  = (k == 0);
      s_out_ready = 1'b1;
      #3;
      checkBit($sformatf("small_sl_c%0d", k), s_sample_load, (k == 0));
      checkBit($sformatf("small_ac_c%0d", k), s_acc_clear, (k == 0));
      checkBit($sformatf("small_iv_c%0d", k), s_issue_valid, (k == 1 || k == 2));
      checkBit($sformatf("small_tap_c%0d", k), s_tap_sel[0], (k == 2));
      checkBit($sformatf("small_al_c%0d", k), s_acc_load, (k == 2 || k == 3));
      checkBit($sformatf("small_ov_c%0d", k), s_out_valid, (k == 4));
      checkBit($sformatf("small_busy_c%0d", k), s_busy, (k >= 1 && k <= 4));
    end

    // Small instance: in_valid held high, accepts every 5 cycles.
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1 s_in_valid = 1'b1;
      #3;
      checkBit($sformatf("b2b_sl_c%0d", k), s_sample_load, ((k % 5) == 0));
      checkBit($sformatf("b2b_ir_c%0d", k), s_in_ready, ((k % 5) == 0));
      checkBit($sformatf("b2b_al_c%0d", k), s_acc_load, ((k % 5) == 2 || (k % 5) == 3));
      checkBit($sformatf("b2b_ov_c%0d", k), s_out_valid, ((k % 5) == 4));
    end
    s_in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
